// File: rtl/ascii_alu_pkg.sv
// Shared definitions for the sequential ASCII ALU: opcode bit positions,
// FSM states, display characters and BCD sizing.
package ascii_alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_MOD = 4;
  localparam int OP_AND = 5;
  localparam int OP_OR  = 6;
  localparam int OP_XOR = 7;
  localparam int OP_NOT = 8;
  localparam int OP_SHL = 9;
  localparam int OP_SHR = 10;
  localparam int NUM_OPS = 11;

  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_R     = 8'h72;

  // ceil(w * log10(2)) using a fixed-point approximation of log10(2)
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2ascii.sv
// Binary to right-justified ASCII decimal: double-dabble over VW cycles,
// then combinational formatting of spaces, sign and overflow.
module bin2ascii
  import ascii_alu_pkg::*;
#(
  parameter int VW     = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VW-1:0]         value,
  input  logic                  neg,
  output logic                  ready,
  output logic [8*DIGITS-1:0]   display
);

  localparam int BD = bcd_digits(VW);
  localparam int CW = $clog2(VW + 1);

  logic [VW-1:0]      bin;
  logic [4*BD-1:0]    bcd;
  logic [4*BD-1:0]    bcd_adj;
  logic [4*BD+VW-1:0] shifted;
  logic [CW-1:0]      cnt;
  logic               neg_r;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BD; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      neg_r <= 1'b0;
    end else if (start) begin
      bin   <= value;
      bcd   <= '0;
      cnt   <= CW'(VW);
      neg_r <= neg;
    end else if (cnt != '0) begin
      {bcd, bin} <= shifted;
      cnt        <= cnt - CW'(1);
    end
  end

  assign ready = (cnt == '0);

  int              nd;
  logic [4*BD-1:0] rest;

  // nd counts significant digits; a zero value still shows one '0'
  always_comb begin
    nd = 1;
    for (int i = 0; i < BD; i++) begin
      if (bcd[4*i +: 4] != 4'd0) nd = i + 1;
    end
    rest    = bcd;
    display = {DIGITS{ASCII_SP}};
    if (nd + int'(neg_r) > DIGITS) begin
      display = {DIGITS{ASCII_HASH}};
    end else begin
      for (int p = 0; p < DIGITS; p++) begin
        if (p < nd) display[8*p +: 8] = ASCII_0 | {4'd0, rest[3:0]};
        else if (neg_r && p == nd) display[8*p +: 8] = ASCII_MINUS;
        rest = rest >> 4;
      end
    end
  end

endmodule

// File: rtl/ascii_alu_seq.sv
// Multi-cycle ASCII ALU: captures operands on go, runs the operation
// (iterative shift-add multiply, restoring divide) and formats the result.
module ascii_alu_seq
  import ascii_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [10:0]           op_code,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    result,
  output logic                  neg,
  output logic                  error,
  output logic [8*DIGITS-1:0]   display
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_n;

  logic [WIDTH-1:0] a_r, b_r, mplier, quo, rem, quo_n, rem_n, diff;
  logic [10:0]      op_r;
  logic             err_r, err_in, iter_in, op_ok, exec_last, start, ge;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    acc, mcand, acc_n, simple_val, exec_val, res_r;
  logic             simple_neg, neg_r, conv_ready;
  logic [WIDTH:0]   sh;
  logic [8*DIGITS-1:0] conv_display, err_display;

  assign op_ok   = (op_code != '0) && ((op_code & (op_code - 11'd1)) == '0);
  assign err_in  = !op_ok || ((op_code[OP_DIV] || op_code[OP_MOD]) && b == '0);
  assign iter_in = op_code[OP_MUL] | op_code[OP_DIV] | op_code[OP_MOD];
  assign exec_last = (state == EXEC) && (cnt == '0);

  always_comb begin
    acc_n = acc + (mplier[0] ? mcand : '0);
    sh    = {rem, quo[WIDTH-1]};
    ge    = sh >= {1'b0, b_r};
    diff  = sh[WIDTH-1:0] - b_r;
    rem_n = ge ? diff : sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
  end

  always_comb begin
    simple_val = '0;
    simple_neg = 1'b0;
    if (op_r[OP_ADD]) simple_val = {{WIDTH{1'b0}}, a_r} + {{WIDTH{1'b0}}, b_r};
    else if (op_r[OP_SUB]) begin
      if (a_r >= b_r) simple_val = {{WIDTH{1'b0}}, a_r - b_r};
      else begin
        simple_val = {{WIDTH{1'b0}}, b_r - a_r};
        simple_neg = 1'b1;
      end
    end
    else if (op_r[OP_AND]) simple_val = {{WIDTH{1'b0}}, a_r & b_r};
    else if (op_r[OP_OR])  simple_val = {{WIDTH{1'b0}}, a_r | b_r};
    else if (op_r[OP_XOR]) simple_val = {{WIDTH{1'b0}}, a_r ^ b_r};
    else if (op_r[OP_NOT]) simple_val = {{WIDTH{1'b0}}, ~a_r};
    else if (op_r[OP_SHL]) simple_val = (32'(b_r) >= RW) ? '0 : ({{WIDTH{1'b0}}, a_r} << b_r);
    else if (op_r[OP_SHR]) simple_val = {{WIDTH{1'b0}}, a_r >> b_r};

    if (op_r[OP_MUL])      exec_val = acc_n;
    else if (op_r[OP_DIV]) exec_val = {{WIDTH{1'b0}}, quo_n};
    else if (op_r[OP_MOD]) exec_val = {{WIDTH{1'b0}}, rem_n};
    else                   exec_val = simple_val;
  end

  // Errors get a two-cycle EXEC so done lands two edges after go
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= '0; b_r <= '0; op_r <= '0; err_r <= 1'b0; cnt <= '0;
      acc <= '0; mcand <= '0; mplier <= '0; quo <= '0; rem <= '0;
      res_r <= '0; neg_r <= 1'b0;
    end else if (state == IDLE && go) begin
      a_r    <= a;
      b_r    <= b;
      op_r   <= op_code;
      err_r  <= err_in;
      cnt    <= err_in ? CW'(1) : (iter_in ? CW'(WIDTH - 1) : '0);
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      quo    <= a;
      rem    <= '0;
    end else if (state == EXEC) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      quo    <= quo_n;
      rem    <= rem_n;
      res_r  <= exec_val;
      neg_r  <= simple_neg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (go) state_n = EXEC;
      EXEC: if (cnt == '0) state_n = err_r ? DONE : CONV;
      CONV: if (conv_ready) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == EXEC) || (state == CONV);
    done  = (state == DONE);
    start = exec_last && !err_r;
  end

  bin2ascii #(.VW(RW), .DIGITS(DIGITS)) u_bin2ascii (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .value   (exec_val),
    .neg     (simple_neg),
    .ready   (conv_ready),
    .display (conv_display)
  );

  always_comb begin
    err_display        = {DIGITS{ASCII_SP}};
    err_display[23:0]  = {ASCII_E, ASCII_R, ASCII_R};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      neg     <= 1'b0;
      error   <= 1'b0;
      display <= {DIGITS{ASCII_SP}};
    end else if (exec_last && err_r) begin
      result  <= '0;
      neg     <= 1'b0;
      error   <= 1'b1;
      display <= err_display;
    end else if (state == CONV && conv_ready) begin
      result  <= res_r;
      neg     <= neg_r;
      error   <= 1'b0;
      display <= conv_display;
    end
  end

endmodule

// File: tb/tb_ascii_alu_seq.sv
// Directed self-checking bench for ascii_alu_seq (5-digit and 4-digit builds).
module tb_ascii_alu_seq;

  localparam logic [10:0] OPC_ADD = 11'b00000000001;
  localparam logic [10:0] OPC_SUB = 11'b00000000010;
  localparam logic [10:0] OPC_MUL = 11'b00000000100;
  localparam logic [10:0] OPC_DIV = 11'b00000001000;
  localparam logic [10:0] OPC_MOD = 11'b00000010000;
  localparam logic [10:0] OPC_XOR = 11'b00010000000;
  localparam logic [10:0] OPC_SHL = 11'b01000000000;

  logic        clk = 1'b0;
  logic        reset, go;
  logic [7:0]  a, b;
  logic [10:0] op_code;

  logic        busy, done, neg, error;
  logic [15:0] result;
  logic [39:0] display;
  logic        busy4, done4, neg4, error4;
  logic [15:0] result4;
  logic [31:0] display4;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic bsy;
  int seen;

  always #5 clk = ~clk;

  ascii_alu_seq #(.WIDTH(8), .DIGITS(5)) dut (
    .clk(clk), .reset(reset), .go(go), .a(a), .b(b), .op_code(op_code),
    .busy(busy), .done(done), .result(result), .neg(neg), .error(error),
    .display(display)
  );

  ascii_alu_seq #(.WIDTH(8), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .go(go), .a(a), .b(b), .op_code(op_code),
    .busy(busy4), .done(done4), .result(result4), .neg(neg4), .error(error4),
    .display(display4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns edges from accept to done (-1 on timeout) and busy after accept
  task automatic run(input logic [10:0] op, input logic [7:0] aa, input logic [7:0] bb,
                     output int l, output logic bz);
    repeat (2) @(negedge clk);
    a = aa; b = bb; op_code = op; go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    bz = busy;
    l = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; a = '0; b = '0; op_code = '0;
    #2;
    chk("rst_display", display, 40'h2020202020);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'd0);
    chk("rst_neg_err", {neg, error}, 2'b00);
    #8 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy_done", {busy, done}, 2'b00);
    chk("idle_display", display, 40'h2020202020);

    run(OPC_XOR, 8'd2, 8'd0, lat, bsy);
    chk("xor_latency", lat, 18);
    chk("xor_busy", bsy, 1'b1);
    chk("xor_result", result, 16'd2);
    chk("xor_display", display, 40'h2020202032);
    chk("xor_display4", display4, 32'h20202032);
    chk("xor_flags", {busy, neg, error}, 3'b000);

    run(OPC_MUL, 8'd255, 8'd255, lat, bsy);
    chk("mul_latency", lat, 25);
    chk("mul_result", result, 16'd65025);
    chk("mul_display", display, 40'h3635303235);
    chk("mul_display4", display4, 32'h23232323);
    chk("mul_error4", error4, 1'b0);

    run(OPC_SUB, 8'd3, 8'd10, lat, bsy);
    chk("sub_latency", lat, 18);
    chk("sub_neg", neg, 1'b1);
    chk("sub_result", result, 16'd7);
    chk("sub_display", display, 40'h2020202D37);

    run(OPC_MOD, 8'd200, 8'd7, lat, bsy);
    chk("mod_latency", lat, 25);
    chk("mod_display", display, 40'h2020202034);
    chk("mod_neg", neg, 1'b0);

    run(OPC_DIV, 8'd200, 8'd7, lat, bsy);
    chk("div_result", result, 16'd28);

    run(OPC_ADD, 8'd0, 8'd0, lat, bsy);
    chk("add_zero_display", display, 40'h2020202030);

    run(OPC_SHL, 8'd255, 8'd8, lat, bsy);
    chk("shl8_result", result, 16'd65280);
    chk("shl8_display", display, 40'h3635323830);

    run(OPC_SHL, 8'd1, 8'd16, lat, bsy);
    chk("shl16_result", result, 16'd0);

    run(OPC_DIV, 8'd7, 8'd0, lat, bsy);
    chk("div0_latency", lat, 2);
    chk("div0_error", error, 1'b1);
    chk("div0_display", display, 40'h2020457272);
    chk("div0_result", result, 16'd0);

    run(OPC_SHL, 8'd1, 8'd1, lat, bsy);
    chk("shl1_clears_error", {error, result}, {1'b0, 16'd2});

    run(11'b00000000011, 8'd5, 8'd5, lat, bsy);
    chk("multihot_latency", lat, 2);
    chk("multihot_error", error, 1'b1);
    chk("multihot_display", display, 40'h2020457272);

    // go pulsed during a multiply must not disturb it
    repeat (2) @(negedge clk);
    a = 8'd12; b = 8'd11; op_code = OPC_MUL; go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        go = 1'b1; a = 8'd1; b = 8'd1; op_code = OPC_ADD;
      end else go = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    go = 1'b0;
    chk("midgo_latency", lat, 25);
    chk("midgo_result", result, 16'd132);
    chk("midgo_display", display, 40'h2020313332);

    // reset while converting
    repeat (2) @(negedge clk);
    a = 8'd9; b = 8'd9; op_code = OPC_ADD; go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("conv_rst_display", display, 40'h2020202020);
    chk("conv_rst_result", result, 16'd0);
    chk("conv_rst_flags", {busy, done, neg, error}, 4'b0000);
    #10 reset = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("conv_rst_no_done", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
